// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset SoC: program ROM, data RAM, LED/switch/7-segment and UART MMIO.
// The built-in program reads two bytes over UART and returns their GCD on UART, LEDs and display.
module single_cycle_cpu #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    input  logic        UART_RX,
    output logic        UART_TX
);
    localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_SLT = 6'h2A;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // GCD program; $8 is built up to the MMIO base 0x40000000 because there is no lui.
    function automatic logic [31:0] rom_word(input logic [5:0] a);
        if (a >= 6'd1 && a <= 6'd16) return 32'h01084020;
        case (a)
            6'd0:  return 32'h20084000;
            6'd17: return 32'h8D090018;
            6'd18: return 32'h31290001;
            6'd19: return 32'h1120FFFD;
            6'd20: return 32'h8D0A0014;
            6'd21: return 32'h8D090018;
            6'd22: return 32'h31290001;
            6'd23: return 32'h1120FFFD;
            6'd24: return 32'h8D0B0014;
            6'd25: return 32'h11400008;
            6'd26: return 32'h11600008;
            6'd27: return 32'h114B0007;
            6'd28: return 32'h014B602A;
            6'd29: return 32'h15800002;
            6'd30: return 32'h014B5022;
            6'd31: return 32'h0800001B;
            6'd32: return 32'h016A5822;
            6'd33: return 32'h0800001B;
            6'd34: return 32'h01605020;
            6'd35: return 32'hAD0A0000;
            6'd36: return 32'hAD0A0008;
            6'd37: return 32'h8D090018;
            6'd38: return 32'h31290002;
            6'd39: return 32'h1520FFFD;
            6'd40: return 32'hAD0A0010;
            6'd41: return 32'h08000011;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] seg_font(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] rf_q   [32];
    logic [31:0] dmem_q [32];
    logic [7:0]  led_q, led_d;
    logic [15:0] disp_q, disp_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [2:0]  rx_sync_q, rx_bit_q, rx_bit_d;
    logic [31:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, scan_cnt_q, scan_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d, tx_busy_q, tx_busy_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [1:0]  digit_q, digit_d;

    logic [31:0] instr, rs_val, rt_val, simm, zimm, alu, rdata, rf_wdata;
    logic [4:0]  rf_waddr;
    logic [2:0]  reg_idx;
    logic        rf_we, mem_rd, mem_wr, mmio_sel, dmem_sel, mmio_wr, rx_rd;

    assign instr    = rom_word(pc_q[7:2]);
    assign rs_val   = rf_q[instr[25:21]];
    assign rt_val   = rf_q[instr[20:16]];
    assign simm     = {{16{instr[15]}}, instr[15:0]};
    assign zimm     = {16'h0, instr[15:0]};
    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        alu      = '0;
        rf_we    = 1'b0;
        rf_waddr = instr[20:16];
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        pc_d     = pc_plus4;
        case (instr[31:26])
            OP_RTYPE: if (instr[10:6] == 5'd0) begin
                rf_we    = 1'b1;
                rf_waddr = instr[15:11];
                case (instr[5:0])
                    FN_ADD:  alu = rs_val + rt_val;
                    FN_SUB:  alu = rs_val - rt_val;
                    FN_AND:  alu = rs_val & rt_val;
                    FN_OR:   alu = rs_val | rt_val;
                    FN_SLT:  alu = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    default: rf_we = 1'b0;
                endcase
            end
            OP_ADDI: begin alu = rs_val + simm; rf_we = 1'b1; end
            OP_ANDI: begin alu = rs_val & zimm; rf_we = 1'b1; end
            OP_LW:   begin alu = rs_val + simm; rf_we = 1'b1; mem_rd = 1'b1; end
            OP_SW:   begin alu = rs_val + simm; mem_wr = 1'b1; end
            OP_BEQ:  if (rs_val == rt_val) pc_d = pc_plus4 + (simm << 2);
            OP_BNE:  if (rs_val != rt_val) pc_d = pc_plus4 + (simm << 2);
            OP_J:    pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: ;
        endcase
        if (rf_waddr == 5'd0) rf_we = 1'b0;
    end

    assign mmio_sel = (alu[31:5] == 27'h200_0000) && (alu[1:0] == 2'b00);
    assign dmem_sel = (alu[31:7] == 25'h0) && (alu[1:0] == 2'b00);
    assign reg_idx  = alu[4:2];
    assign mmio_wr  = mem_wr && mmio_sel;
    assign rx_rd    = mem_rd && mmio_sel && (reg_idx == 3'd5);

    always_comb begin
        rdata = '0;
        if (dmem_sel) begin
            rdata = dmem_q[alu[6:2]];
        end else if (mmio_sel) begin
            case (reg_idx)
                3'd0:    rdata = {24'h0, led_q};
                3'd1:    rdata = {24'h0, switch};
                3'd2:    rdata = {16'h0, disp_q};
                3'd5:    rdata = {24'h0, rx_data_q};
                3'd6:    rdata = {30'h0, tx_busy_q, rx_valid_q};
                default: rdata = '0;
            endcase
        end
        rf_wdata = mem_rd ? rdata : alu;
    end

    always_comb begin
        led_d      = led_q;
        disp_d     = disp_q;
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        scan_cnt_d = scan_cnt_q + 32'd1;
        digit_d    = digit_q;

        if (mmio_wr && reg_idx == 3'd0) led_d  = rt_val[7:0];
        if (mmio_wr && reg_idx == 3'd2) disp_d = rt_val[15:0];

        if (tx_busy_q) begin
            tx_cnt_d = tx_cnt_q + 32'd1;
            if (tx_cnt_q == BAUD_DIV - 1) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
            end
        end else if (mmio_wr && reg_idx == 3'd4) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, rt_val[7:0], 1'b0};
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
        end

        // A byte completing in the same cycle as a read of RX data wins: it sets rx_valid again.
        if (rx_rd) rx_valid_d = 1'b0;
        rx_cnt_d = rx_cnt_q + 32'd1;
        case (rx_state_q)
            RX_IDLE: if (rx_sync_q[2] && !rx_sync_q[1]) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            RX_START: if (rx_cnt_q == HALF_DIV - 1) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BAUD_DIV - 1) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BAUD_DIV - 1) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                if (rx_sync_q[1]) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        if (scan_cnt_q == SCAN_DIV - 1) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
    end

    // NOTE: register file and data RAM are cleared by reset, so both are built from resettable flops.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i]   <= '0;
                dmem_q[i] <= '0;
            end
            led_q      <= '0;
            disp_q     <= '0;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            rx_sync_q  <= 3'b111;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            scan_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            // NOTE: state updates are non-blocking so every flop sees the pre-edge values.
            pc_q <= pc_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
            if (mem_wr && dmem_sel) dmem_q[alu[6:2]] <= rt_val;
            led_q      <= led_d;
            disp_q     <= disp_d;
            tx_busy_q  <= tx_busy_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_sync_q  <= {rx_sync_q[1:0], UART_RX};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
        end
    end

    always_comb begin
        digi[11:8] = ~(4'b0001 << digit_q);
        case (digit_q)
            2'd0:    digi[7:0] = seg_font(disp_q[3:0]);
            2'd1:    digi[7:0] = seg_font(disp_q[7:4]);
            2'd2:    digi[7:0] = seg_font(disp_q[11:8]);
            default: digi[7:0] = seg_font(disp_q[15:12]);
        endcase
    end

    assign led     = led_q;
    assign UART_TX = tx_busy_q ? tx_shift_q[0] : 1'b1;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: sends UART byte pairs, decodes the returned frames against a
// queue of expected GCDs, and checks LEDs, 7-segment digits, reset and bad-frame handling.
module tb_single_cycle_cpu;
    localparam int BIT  = 16;  // 1.6 MHz / 100 kbaud
    localparam int SCAN = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] gcd;
        logic [7:0] seg0;
        logic [7:0] seg1;
    } vec_t;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  switch = 8'h5A;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        UART_RX = 1'b1;
    logic        UART_TX;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          frames_seen = 0;
    int unsigned b_mid_cyc = 0;
    logic [7:0]  exp_q[$];

    single_cycle_cpu #(.CLK_FREQ(1_600_000), .BAUD(100_000), .SCAN_DIV(SCAN)) dut (
        .sysclk(sysclk), .reset(reset), .switch(switch), .led(led), .digi(digi),
        .UART_RX(UART_RX), .UART_TX(UART_TX)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // abort_at >= 0 pulls reset low in the middle of that data bit and abandons the frame.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int abort_at,
                             input bit mark_b);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            UART_RX = fr[i];
            if (abort_at >= 0 && i == abort_at + 1) begin
                repeat (BIT / 2) @(negedge sysclk);
                reset   = 1'b0;
                UART_RX = 1'b1;
                repeat (5) @(negedge sysclk);
                reset = 1'b1;
                return;
            end
            if (i == 9 && mark_b) b_mid_cyc = cyc + BIT / 2;
            repeat (BIT - 1) @(negedge sysclk);
        end
        @(negedge sysclk);
        UART_RX = 1'b1;
    endtask

    task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input logic [7:0] gcd);
        int target;
        target = frames_seen + 1;
        send_byte(a, 1'b1, -1, 1'b0);
        repeat (2 * BIT) @(negedge sysclk);
        exp_q.push_back(gcd);
        send_byte(b, 1'b1, -1, 1'b1);
        for (int k = 0; k < 6000 && frames_seen < target; k++) @(negedge sysclk);
        check($sformatf("tx_frames_after_%0d_%0d", a, b), frames_seen, target);
        repeat (BIT) @(negedge sysclk);
    endtask

    task automatic check_digit(input int k, input logic [7:0] seg);
        logic [3:0] en_exp;
        int         n;
        en_exp = ~(4'b0001 << k);
        n = 0;
        while (digi[8 + k] !== 1'b0 && n < 8 * SCAN) begin
            @(negedge sysclk);
            n++;
        end
        check($sformatf("digit%0d_enable", k), {28'h0, digi[11:8]}, {28'h0, en_exp});
        check($sformatf("digit%0d_segments", k), {24'h0, digi[7:0]}, {24'h0, seg});
    endtask

    // TX monitor: decode each frame mid-bit and compare against the scoreboard head.
    initial begin : tx_mon
        forever begin
            @(negedge UART_TX);
            if (reset) begin
                int unsigned t0;
                logic [7:0]  d;
                logic [7:0]  e;
                logic [7:0]  led_at_start;
                t0 = cyc;
                led_at_start = led;
                repeat (BIT / 2) @(negedge sysclk);
                check("tx_start_bit", {31'h0, UART_TX}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge sysclk);
                    d[i] = UART_TX;
                end
                repeat (BIT) @(negedge sysclk);
                check("tx_stop_bit", {31'h0, UART_TX}, 32'h1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected no frame", d);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'h0, d}, {24'h0, e});
                    check("led_at_tx", {24'h0, led_at_start}, {24'h0, e});
                    check("latency_within_3100", (t0 - b_mid_cyc <= 3100) ? 32'h1 : 32'h0, 32'h1);
                end
                frames_seen++;
            end
        end
    end

    initial begin : main
        vec_t vecs[6];
        int   tx_low;
        vecs[0] = '{8'd84,  8'd12,  8'h0C, 8'hC6, 8'hC0};
        vecs[1] = '{8'd0,   8'd25,  8'h19, 8'h90, 8'hF9};
        vecs[2] = '{8'd17,  8'd5,   8'h01, 8'hF9, 8'hC0};
        vecs[3] = '{8'd255, 8'd255, 8'hFF, 8'h8E, 8'h8E};
        vecs[4] = '{8'd0,   8'd0,   8'h00, 8'hC0, 8'hC0};
        vecs[5] = '{8'd1,   8'd255, 8'h01, 8'hF9, 8'hC0};

        reset   = 1'b0;
        UART_RX = 1'b1;
        #10;
        reset = 1'b1;

        tx_low = 0;
        repeat (80) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1) tx_low++;
        end
        check("idle_tx_low_cycles", tx_low, 0);
        check("led_after_reset", {24'h0, led}, 32'h0);
        for (int k = 0; k < 4; k++) check_digit(k, 8'hC0);

        for (int i = 0; i < 6; i++) begin
            run_pair(vecs[i].a, vecs[i].b, vecs[i].gcd);
            check($sformatf("led_pair%0d", i), {24'h0, led}, {24'h0, vecs[i].gcd});
            check_digit(0, vecs[i].seg0);
            check_digit(1, vecs[i].seg1);
        end

        // Reset in the middle of B's data bits: the half-received pair must never be answered.
        send_byte(8'd100, 1'b1, -1, 1'b0);
        repeat (2 * BIT) @(negedge sysclk);
        send_byte(8'd50, 1'b1, 4, 1'b0);
        @(negedge sysclk);
        check("led_after_abort", {24'h0, led}, 32'h0);
        check_digit(0, 8'hC0);
        repeat (4 * BIT) @(negedge sysclk);
        run_pair(8'd48, 8'd18, 8'h06);
        check_digit(0, 8'h82);

        // Frame with a low stop bit is dropped, so 9,6 pairs up correctly.
        send_byte(8'h77, 1'b0, -1, 1'b0);
        repeat (3 * BIT) @(negedge sysclk);
        run_pair(8'd9, 8'd6, 8'h03);
        check("led_after_bad_stop", {24'h0, led}, 32'h03);
        check_digit(0, 8'hB0);

        repeat (4000) @(negedge sysclk);
        check("frames_total", frames_seen, 8);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/single_cycle_cpu.md
Name: single_cycle_cpu

Overview:
- Self-contained single-cycle processor SoC: 32-bit MIPS-subset core, fixed program ROM, data memory and memory-mapped UART, LED, switch and 7-segment peripherals.
- The built-in program waits for two unsigned bytes on UART and computes their GCD.
- It returns the GCD on UART, drives it onto the LEDs and shows it on the 7-segment display, then waits for the next pair.
- Top-level block of the board design.

Parameters:
- CLK_FREQ, 100000000, sysclk frequency in Hz.
- BAUD, 9600, UART bit rate; bit period = CLK_FREQ/BAUD = 10417 clocks.
- SCAN_DIV, 100000, clocks per 7-segment digit scan step.

Ports:
- sysclk  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- switch  input  8  board switches, readable by program (unused by GCD program).
- led  output  8  LED register.
- digi  output  12  [11:8] digit enables, one-hot active-low (bit 11 = leftmost); [7:0] segments {dp,g,f,e,d,c,b,a}, active-low.
- UART_RX  input  1  serial in, idle high.
- UART_TX  output  1  serial out, idle high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- On reset low: PC=0; registers, data memory, led and all peripheral registers = 0; UART_TX=1; RX/TX FSMs idle.
- Digit scan restarts at digit 0; digi shows "0000".
- Reset asserted mid-frame or mid-computation aborts everything; operation resumes from PC=0 on release.
- Core: one instruction per sysclk; 32 registers, $0 hardwired to 0.
- ISA: add, sub, and, or, slt, addi, andi, lw, sw, beq, bne, j. Standard MIPS encodings, signed 16-bit immediates sign-extended, branch target = PC+4+(imm<<2).
- Instruction ROM: 64 words, combinational read. Data memory: 32 words, word addressed, synchronous write.
- MMIO (lw/sw):
  - 0x40000000 led (RW, low 8 bits).
  - 0x40000004 switch (R).
  - 0x40000008 display value (RW, low 16 bits = 4 hex digits).
  - 0x40000010 TX data (W, write starts a frame).
  - 0x40000014 RX data (R).
  - 0x40000018 status (R): bit0 rx_valid, cleared by reading RX data; bit1 tx_busy.
- UART RX: 8N1, LSB first.
  - Start bit detected on falling edge, sampled at mid-bit (BAUD_DIV/2), then every BAUD_DIV clocks.
  - Byte latched and rx_valid set at the middle of the stop bit.
  - Bad stop bit (0): byte discarded.
  - A new byte while rx_valid=1 overwrites the data.
- UART TX: 8N1, LSB first; a write while tx_busy is ignored.
- Program:
  - Poll rx_valid, read A; poll again, read B.
  - Compute gcd(A,B) by repeated subtraction; gcd(x,0)=gcd(0,x)=x, gcd(0,0)=0.
  - Write result to led and to the display as 0x00RR.
  - Wait for !tx_busy, send the result byte, loop.
- Latency: result visible on led within 3000 clocks after B's stop-bit middle; TX start bit begins within a further 100 clocks.
- Display:
  - One digit enabled per SCAN_DIV period, cycling 0→1→2→3 (rightmost = digit 0 = bit 8).
  - Hex font 0-F; dp always off (1).

Test Plan:
- Reset low 10 ns then high; hold RX=1 → led=0x00, UART_TX=1 throughout, digi segments show '0' (0xC0) on each scanned digit.
- Send 84 (0x54) then 12 (0x0C) at 9600 baud → led=0x0C; UART_TX emits start,0,0,1,1,0,0,0,0,stop; digit0 shows 'C' (0xC6), digit1 shows '0' (0xC0).
- Send 0 then 25 → led=0x19, TX byte 0x19; then send 17,5 without reset → led=0x01, TX 0x01.
- Send 255,255 → led=0xFF, TX 0xFF; send 0,0 → led=0x00, TX 0x00 (no hang).
- Assert reset halfway through B's data bits, release, send 48,18 → led=0x06, TX 0x06 only (no output from the aborted pair).
- Send a frame with stop bit 0 → ignored; a following valid pair 9,6 → led=0x03.
